// File: rtl/serial_subtractor8_if.sv
// serial_subtractor8_if
//   Handshake/data bundle for the bit-serial subtractor.
//   master : requester side, which drives start/a/b and observes the result.
//   slave  : subtractor side, which samples start/a/b and drives busy/done/f/ovf/borrow.
//   Signals:
//     start  - request an operation (taken only while busy=0)
//     a, b   - minuend / subtrahend, WIDTH bits
//     busy   - operation in progress
//     done   - one-cycle pulse when f/ovf/borrow have just been updated
//     f      - a - b modulo 2^WIDTH
//     ovf    - signed overflow of a - b
//     borrow - unsigned borrow (a < b)
interface serial_subtractor8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             ovf;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, f, ovf, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, f, ovf, borrow
    );
endinterface

// File: rtl/serial_subtractor8.sv
// serial_subtractor8
//   Bit-serial WIDTH-bit two's-complement subtractor, f = a - b, LSB first.
//   A single full-adder cell is iterated over shift registers to compute
//   a + ~b + 1, one bit per clock. An operation accepted on an edge completes
//   exactly WIDTH edges later, with a one-cycle done pulse.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - serial_subtractor8_if.slave (start/a/b in; busy/done/f/ovf/borrow out)
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor8_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;     // holds ~b; the +1 comes from the initial carry
    logic [WIDTH-1:0] sh_r;     // partial result, filled from the MSB side
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] f_q;
    logic             ovf_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    // Full-adder cell
    logic sum_bit;
    logic carry_out;

    assign sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_out = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            sh_r     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            f_q      <= '0;
            ovf_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE, so operations
                // can run back to back without a dead cycle.
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= ~bus.b;
                        sh_r   <= '0;
                        carry  <= 1'b1;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    sh_r  <= {sum_bit, sh_r[WIDTH-1:1]};
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= carry_out;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Final bit: carry holds the carry into the MSB here,
                        // carry_out is the carry out of it. Results are written
                        // only now, so they never show a partial value.
                        f_q      <= {sum_bit, sh_r[WIDTH-1:1]};
                        ovf_q    <= carry ^ carry_out;
                        borrow_q <= ~carry_out;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= ST_DONE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.f      = f_q;
    assign bus.ovf    = ovf_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
// tb_serial_subtractor8
//   Directed bench for serial_subtractor8 (WIDTH=8). Inputs are driven and
//   outputs sampled on the falling edge; expected values are hand-computed.
module tb_serial_subtractor8;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    logic [7:0] last_f;

    serial_subtractor8_if #(.WIDTH(8)) bus ();

    serial_subtractor8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one operation from a falling edge and follow it cycle by cycle.
    // Returns at the falling edge of the done cycle.
    task automatic op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ef, input logic eo, input logic eb);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'(~ia);
        bus.b     = 8'(ib + 8'd37);
        chk({tag, ".acc"}, {30'd0, bus.busy, bus.done}, 32'b10);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk({tag, ".run"}, {22'd0, bus.busy, bus.done, bus.f}, {22'd0, 2'b10, last_f});
        end
        @(negedge clk);
        chk({tag, ".done"}, {30'd0, bus.busy, bus.done}, 32'b01);
        chk({tag, ".f"},    {24'd0, bus.f}, {24'd0, ef});
        chk({tag, ".flag"}, {30'd0, bus.ovf, bus.borrow}, {30'd0, eo, eb});
        last_f = ef;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        last_f    = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;

        #3;
        chk("rst", {27'd0, bus.busy, bus.done, bus.ovf, bus.borrow, |bus.f}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle", {30'd0, bus.busy, bus.done}, 32'd0);

        op("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("pulse1", {30'd0, bus.busy, bus.done}, 32'd0);
        op("03-05", 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
        @(negedge clk);
        op("80-01", 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
        @(negedge clk);
        op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        op("5A-5A", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        op("00-80", 8'h00, 8'h80, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        op("C3-00", 8'hC3, 8'h00, 8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold", {24'd0, bus.f}, 32'h0000_00C3);

        // start while busy is ignored; a/b changes mid-run have no effect
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign.acc", {30'd0, bus.busy, bus.done}, 32'b10);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("ign.run", {22'd0, bus.busy, bus.done, bus.f}, {22'd0, 2'b10, last_f});
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
            end else if (i == 4) begin
                bus.start = 1'b0;
                bus.a     = 8'h33;
                bus.b     = 8'h77;
            end
        end
        @(negedge clk);
        chk("ign.done", {30'd0, bus.busy, bus.done}, 32'b01);
        chk("ign.f", {24'd0, bus.f}, 32'h0000_000F);
        chk("ign.flag", {30'd0, bus.ovf, bus.borrow}, 32'd0);
        last_f = 8'h0F;

        // back-to-back: start in the done cycle
        op("b2b", 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b.idle", {30'd0, bus.busy, bus.done}, 32'd0);

        // asynchronous reset mid-operation
        bus.start = 1'b1;
        bus.a     = 8'h22;
        bus.b     = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre.rst", {30'd0, bus.busy, bus.done}, 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("arst.f", {24'd0, bus.f}, 32'd0);
        chk("arst.flag", {30'd0, bus.ovf, bus.borrow}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_f = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("arst.quiet", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        op("post", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("post.idle", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
